// File: rtl/blur_window_sequencer.sv
// blur_window_sequencer: two line buffers plus a 3x3 shift window feeding the box-blur averager.
// Optional macro BLUR_RUNTIME_BYPASS_EN adds blur_en, which replaces every window tap with the centre pixel.
module blur_window_sequencer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
`ifdef BLUR_RUNTIME_BYPASS_EN
    input  logic             blur_en,
`endif
    output logic [PIX_W-1:0] win_lu,
    output logic [PIX_W-1:0] win_mu,
    output logic [PIX_W-1:0] win_ru,
    output logic [PIX_W-1:0] win_lm,
    output logic [PIX_W-1:0] win_mm,
    output logic [PIX_W-1:0] win_rm,
    output logic [PIX_W-1:0] win_ld,
    output logic [PIX_W-1:0] win_md,
    output logic [PIX_W-1:0] win_rd,
    output logic             win_valid,
    output logic             win_sof,
    output logic             win_eol,
    output logic             frame_active
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] xLast = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] yLast = YW'(IMG_HEIGHT - 1);
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2;

    logic [1:0] state;
    logic [XW-1:0] x, px, nx;
    logic [YW-1:0] y, py, ny;
    logic accept, xWrap, lastPix, fire, keep;
    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] w [3][3];

    // An accepted in_sof pixel is always (0,0), whatever the counters say.
    always_comb begin
        accept  = in_valid && (in_sof || state != IDLE);
        px      = in_sof ? '0 : x;
        py      = in_sof ? '0 : y;
        xWrap   = px == xLast;
        lastPix = xWrap && py == yLast;
        nx      = xWrap ? '0 : px + 1'b1;
        ny      = xWrap ? py + 1'b1 : py;
        fire    = accept && !in_sof && state == RUN && px >= XW'(2);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[px] <= lb1[px];
            lb1[px] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            win_valid    <= 1'b0;
            win_sof      <= 1'b0;
            win_eol      <= 1'b0;
            frame_active <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] <= '0;
        end else begin
            win_valid <= fire;
            win_sof   <= fire && px == XW'(2) && py == YW'(2);
            win_eol   <= fire && xWrap;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2]      <= lb0[px];
                w[1][2]      <= lb1[px];
                w[2][2]      <= in_pixel;
                x            <= lastPix ? '0 : nx;
                y            <= lastPix ? '0 : ny;
                state        <= lastPix ? IDLE : (ny >= YW'(2) ? RUN : FILL);
                frame_active <= !lastPix;
            end
        end
    end

`ifdef BLUR_RUNTIME_BYPASS_EN
    logic blurReg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blurReg <= 1'b0;
        else if (accept)
            blurReg <= blur_en;
    end
    assign keep = blurReg;
`else
    assign keep = 1'b1;
`endif

    // With blur disabled every tap carries the centre, so the averager passes it through.
    assign win_lu = keep ? w[0][0] : w[1][1];
    assign win_mu = keep ? w[0][1] : w[1][1];
    assign win_ru = keep ? w[0][2] : w[1][1];
    assign win_lm = keep ? w[1][0] : w[1][1];
    assign win_mm = w[1][1];
    assign win_rm = keep ? w[1][2] : w[1][1];
    assign win_ld = keep ? w[2][0] : w[1][1];
    assign win_md = keep ? w[2][1] : w[1][1];
    assign win_rd = keep ? w[2][2] : w[1][1];
endmodule

// File: tb/tb_blur_window_sequencer.sv
// tb_blur_window_sequencer: directed and randomized frames on a 4x4 image against a raster-position model.
module tb_blur_window_sequencer;
    localparam int W = 4, H = 4, P = 12;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
    logic [P-1:0] in_pixel = '0;
    logic [P-1:0] lu, mu, ru, lm, mm, rm, ld, md, rd;
    logic wv, ws, we, fa;
`ifdef BLUR_RUNTIME_BYPASS_EN
    logic blur_en = 1'b1;
`endif
    int tests = 0, fails = 0, pulses = 0;
    int frame [H][W];
    int mx = 0, my = 0;
    bit active = 0;

    always #5 clk = ~clk;

    blur_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
`ifdef BLUR_RUNTIME_BYPASS_EN
        .blur_en(blur_en),
`endif
        .win_lu(lu), .win_mu(mu), .win_ru(ru), .win_lm(lm), .win_mm(mm), .win_rm(rm),
        .win_ld(ld), .win_md(md), .win_rd(rd), .win_valid(wv), .win_sof(ws), .win_eol(we),
        .frame_active(fa)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: remember the frame by raster position; a window exists for every pixel at x>=2, y>=2.
    task automatic sendPix(input bit v, input bit s, input int pixIn, input bit be = 1'b1);
        bit ev = 0, es = 0, ee = 0;
        logic [9*P-1:0] ew = '0;
        int pix, val;
        pix = pixIn & 'hFFF;
        in_valid = v;
        in_sof = s;
        in_pixel = pix[P-1:0];
`ifdef BLUR_RUNTIME_BYPASS_EN
        blur_en = be;
`endif
        if (v && (s || active)) begin
            if (s) begin
                active = 1;
                mx = 0;
                my = 0;
            end
            frame[my][mx] = pix;
            if (!s && mx >= 2 && my >= 2) begin
                ev = 1;
                es = (mx == 2 && my == 2);
                ee = (mx == W - 1);
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        val = be ? frame[my-2+r][mx-2+c] : frame[my-1][mx-1];
                        ew = {ew[8*P-1:0], P'(val)};
                    end
            end
            if (mx == W - 1 && my == H - 1) begin
                active = 0;
                mx = 0;
                my = 0;
            end else if (mx == W - 1) begin
                mx = 0;
                my++;
            end else mx++;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        in_sof = 0;
        check("win_valid", 128'(wv), 128'(ev));
        check("frame_active", 128'(fa), 128'(active));
        check("win_sof", 128'(ws), 128'(es));
        check("win_eol", 128'(we), 128'(ee));
        if (wv) pulses++;
        if (ev) check("window", 128'({lu, mu, ru, lm, mm, rm, ld, md, rd}), 128'(ew));
    endtask

    // mode 0: raster ramp, 1: random, 2: 0xA53 field with 0x123 at (1,1)
    task automatic sendFrame(input int mode, input bit gaps, input bit be = 1'b1);
        int pix;
        pulses = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                pix = mode == 0 ? yy * W + xx : mode == 1 ? int'($urandom) : (xx == 1 && yy == 1) ? 'h123 : 'hA53;
                sendPix(1, xx == 0 && yy == 0, pix, be);
                if (gaps && (mode == 0 || $urandom_range(0, 1) == 1)) sendPix(0, 0, 0, be);
            end
        check("pulse_count", 128'(pulses), 128'(W - 2) * (H - 2));
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) sendPix(1, i == 0, i);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 128'(wv), 128'(0));
        check("reset_active", 128'(fa), 128'(0));
        check("reset_mm", 128'(mm), 128'(0));
        rst = 0;
        for (int i = 0; i < 3; i++) sendPix(1, 0, $urandom);
        sendFrame(0, 0);
        sendFrame(0, 1);
        partial(10);
        sendFrame(1, 0);
        partial(11);
        rst = 1;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 128'(wv), 128'(0));
        check("rst_mid_active", 128'(fa), 128'(0));
        check("rst_mid_window", 128'({lu, mm, rd}), 128'(0));
        active = 0;
        rst = 0;
        sendFrame(1, 1);
        for (int i = 0; i < 5; i++) sendFrame(1, 1);
`ifdef BLUR_RUNTIME_BYPASS_EN
        sendFrame(2, 0, 1'b0);
        sendFrame(2, 1, 1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
